// File: rtl/trace_pkg.sv
// Shared encodings for the MIPS instruction-trace capture unit.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_TRIG = 1'b1;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one synchronous read port.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; it holds its value between pops.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// PC/instruction trace capture with wrap or PC-trigger-stop, drained oldest-first.
module mips_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     en,
    input  logic [ADDR_W-1:0]        pc,
    input  logic [DATA_W-1:0]        instr,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        trig_pc,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     rd_req,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]        rd_ir,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_state_t      state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     post_q, post_d;
    logic              overflow_q, overflow_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] trig_q, trig_d;
    logic              rd_valid_q;
    logic              wr_en, pop;
    logic [AW-1:0]     rd_addr;

    // Oldest entry sits count slots behind the write pointer.
    assign rd_addr = wr_ptr_q - count_q[AW-1:0];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        post_d     = post_q;
        overflow_d = overflow_q;
        mode_d     = mode_q;
        trig_d     = trig_q;
        wr_en      = 1'b0;
        pop        = 1'b0;
        if (arm) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            post_d     = '0;
            overflow_d = 1'b0;
            mode_d     = mode;
            trig_d     = trig_pc;
        end else begin
            unique case (state_q)
                ARMED, POST: begin
                    if (stop) begin
                        state_d = DONE;
                    end else if (en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q == CW'(DEPTH)) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                        if (state_q == ARMED) begin
                            if (mode_q == MODE_TRIG && pc == trig_q) begin
                                if (POST_TRIG == 0) begin
                                    state_d = DONE;
                                end else begin
                                    post_d  = CW'(POST_TRIG);
                                    state_d = POST;
                                end
                            end
                        end else begin
                            post_d = post_q - 1'b1;
                            if (post_q == CW'(1)) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                IDLE, DONE: begin
                    if (rd_req && count_q != '0) begin
                        pop     = 1'b1;
                        count_d = count_q - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            overflow_q <= 1'b0;
            mode_q     <= 1'b0;
            trig_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_q     <= post_d;
            overflow_q <= overflow_d;
            mode_q     <= mode_d;
            trig_q     <= trig_d;
            rd_valid_q <= pop;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_ram (
        .clk    (clk),
        .rst_in (rst_in),
        .we     (wr_en),
        .waddr  (wr_ptr_q),
        .wdata  ({pc, instr}),
        .re     (pop),
        .raddr  (rd_addr),
        .rdata  ({rd_pc, rd_ir})
    );

    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == ARMED) || (state_q == POST);

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed self-checking bench for mips_trace_buffer (DEPTH 16, POST_TRIG 4).
module tb_mips_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        mode = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] rd_pc;
    logic [31:0] rd_ir;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow;
    logic        busy;

    int total = 0;
    int passed = 0;
    int fails = 0;

    mips_trace_buffer #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DEPTH     (16),
        .POST_TRIG (4)
    ) dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .en       (en),
        .pc       (pc),
        .instr    (instr),
        .mode     (mode),
        .trig_pc  (trig_pc),
        .arm      (arm),
        .stop     (stop),
        .rd_req   (rd_req),
        .rd_pc    (rd_pc),
        .rd_ir    (rd_ir),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic m, input logic [31:0] t);
        arm = 1'b1;
        mode = m;
        trig_pc = t;
        step();
        arm = 1'b0;
    endtask

    task automatic cap(input logic [31:0] p);
        en = 1'b1;
        pc = p;
        instr = ~p;
        step();
        en = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic drain(input int n, input logic [31:0] first, input string tag);
        logic [31:0] exp_pc;
        for (int i = 0; i < n; i++) begin
            exp_pc = first + 32'(4 * i);
            rd_req = 1'b1;
            step();
            chk({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, " rd_pc"}, rd_pc, exp_pc);
            chk({tag, " rd_ir"}, rd_ir, ~exp_pc);
        end
        rd_req = 1'b0;
        step();
        chk({tag, " rd_valid end"}, 32'(rd_valid), 32'd0);
        chk({tag, " rd_pc hold"}, rd_pc, exp_pc);
        chk({tag, " count end"}, 32'(count), 32'd0);
    endtask

    initial begin
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset rd_pc", rd_pc, 32'd0);
        chk("reset rd_ir", rd_ir, 32'd0);
        rst_in = 1'b1;
        step();

        // Basic capture of 10 entries and full drain.
        do_arm(1'b0, 32'h0);
        chk("t1 busy armed", 32'(busy), 32'd1);
        chk("t1 count armed", 32'(count), 32'd0);
        for (int k = 0; k < 10; k++) cap(32'h3000 + 32'(4 * k));
        chk("t1 count", 32'(count), 32'd10);
        do_stop();
        chk("t1 busy done", 32'(busy), 32'd0);
        drain(10, 32'h3000, "t1");
        chk("t1 overflow", 32'(overflow), 32'd0);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        chk("t1 empty pop", 32'(rd_valid), 32'd0);

        // Wrap: 20 captures into 16 entries.
        do_arm(1'b0, 32'h0);
        for (int k = 0; k < 20; k++) cap(32'h3000 + 32'(4 * k));
        do_stop();
        chk("t2 count", 32'(count), 32'd16);
        chk("t2 overflow", 32'(overflow), 32'd1);
        drain(16, 32'h3010, "t2");

        // Trigger at 0x3020 with four post-trigger entries.
        do_arm(1'b1, 32'h3020);
        for (int k = 0; k < 12; k++) cap(32'h3000 + 32'(4 * k));
        chk("t3 busy at 0x302c", 32'(busy), 32'd1);
        cap(32'h3030);
        chk("t3 busy after 0x3030", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) cap(32'h3034 + 32'(4 * k));
        chk("t3 count", 32'(count), 32'd13);
        chk("t3 overflow", 32'(overflow), 32'd0);
        drain(13, 32'h3000, "t3");

        // rd_req ignored while armed; arm wins over rd_req.
        do_arm(1'b0, 32'h0);
        for (int k = 0; k < 3; k++) cap(32'h3000 + 32'(4 * k));
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("t4 armed rd_valid", 32'(rd_valid), 32'd0);
        chk("t4 armed count", 32'(count), 32'd3);
        stop = 1'b1;
        en = 1'b1;
        pc = 32'h300c;
        step();
        stop = 1'b0;
        en = 1'b0;
        chk("t4 stop drops en", 32'(count), 32'd3);
        arm = 1'b1;
        rd_req = 1'b1;
        step();
        arm = 1'b0;
        rd_req = 1'b0;
        chk("t4 arm+rd count", 32'(count), 32'd0);
        chk("t4 arm+rd rd_valid", 32'(rd_valid), 32'd0);
        chk("t4 arm+rd busy", 32'(busy), 32'd1);

        // Asynchronous reset in POST.
        do_arm(1'b1, 32'h3008);
        for (int k = 0; k < 4; k++) cap(32'h3000 + 32'(4 * k));
        chk("t5 busy post", 32'(busy), 32'd1);
        chk("t5 count post", 32'(count), 32'd4);
        rst_in = 1'b0;
        #1;
        chk("t5 rst post busy", 32'(busy), 32'd0);
        chk("t5 rst post count", 32'(count), 32'd0);
        chk("t5 rst post overflow", 32'(overflow), 32'd0);
        chk("t5 rst post rd_valid", 32'(rd_valid), 32'd0);
        #1;
        rst_in = 1'b1;
        step();

        // Asynchronous reset with a pop in flight.
        do_arm(1'b0, 32'h0);
        for (int k = 0; k < 20; k++) cap(32'h3000 + 32'(4 * k));
        do_stop();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("t6 rd_valid before rst", 32'(rd_valid), 32'd1);
        chk("t6 overflow before rst", 32'(overflow), 32'd1);
        rst_in = 1'b0;
        #1;
        chk("t6 rst rd_valid", 32'(rd_valid), 32'd0);
        chk("t6 rst count", 32'(count), 32'd0);
        chk("t6 rst overflow", 32'(overflow), 32'd0);
        chk("t6 rst busy", 32'(busy), 32'd0);
        #1;
        rst_in = 1'b1;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
